// File: rtl/plru_replace_d1_pkg.sv
// Shared types and heap-tree helpers for the tree-PLRU replacer.
// Node n of the tree (root n=1, children 2n/2n+1) lives at bit n-1 of a set's state.
package plru_replace_d1_pkg;

    localparam int DEF_WAY_NUM = 4;

    function automatic int plru_bits(input int ways);
        return ways - 1;
    endfunction

    typedef logic [plru_bits(DEF_WAY_NUM)-1:0] plru_state_t;

    typedef enum logic {
        INIT = 1'b0,
        RUN  = 1'b1
    } fsm_state_t;

    function automatic int heap_parent(input int n);
        return n >> 1;
    endfunction

    function automatic int heap_child(input int n, input logic right);
        return 2 * n + (right ? 1 : 0);
    endfunction

    function automatic logic heap_is_left(input int n);
        return (n % 2) == 0;
    endfunction

endpackage

// File: rtl/plru_replace_d1_if.sv
// Request/response bundle between a cache miss path and the PLRU replacer.
interface plru_replace_d1_if #(
    parameter int DEPTH      = 256,
    parameter int WAY_NUM    = 4,
    parameter int WAY_WIDTH  = $clog2(WAY_NUM),
    parameter int ADDR_WIDTH = $clog2(DEPTH)
);
    logic                  ready;
    logic                  lookup_en;
    logic [ADDR_WIDTH-1:0] lookup_idx;
    logic [WAY_NUM-1:0]    lookup_valid;
    logic                  miss_way_valid;
    logic [WAY_WIDTH-1:0]  miss_way;
    logic                  touch_en;
    logic [ADDR_WIDTH-1:0] touch_idx;
    logic [WAY_WIDTH-1:0]  touch_way;

    modport master (
        input  ready, miss_way_valid, miss_way,
        output lookup_en, lookup_idx, lookup_valid, touch_en, touch_idx, touch_way
    );

    modport slave (
        output ready, miss_way_valid, miss_way,
        input  lookup_en, lookup_idx, lookup_valid, touch_en, touch_idx, touch_way
    );
endinterface

// File: rtl/plru_replace_d1_tree.sv
// Combinational tree-PLRU logic for one set: victim walk and touch update.
module plru_tree
    import plru_replace_d1_pkg::*;
#(
    parameter int WAY_NUM   = 4,
    parameter int WAY_WIDTH = $clog2(WAY_NUM)
) (
    input  logic [WAY_NUM-2:0]   bits_in,
    input  logic [WAY_WIDTH-1:0] touch_way,
    output logic [WAY_WIDTH-1:0] victim_way,
    output logic [WAY_NUM-2:0]   bits_out
);

    always_comb begin
        int vnode;
        vnode = 1;
        for (int l = 0; l < WAY_WIDTH; l++) begin
            vnode = heap_child(vnode, bits_in[vnode-1]);
        end
        victim_way = WAY_WIDTH'(vnode - WAY_NUM);
    end

    // Climb from the touched leaf; each ancestor is steered to the other subtree.
    always_comb begin
        int unode;
        int pnode;
        bits_out = bits_in;
        unode    = WAY_NUM + int'(touch_way);
        for (int l = 0; l < WAY_WIDTH; l++) begin
            pnode             = heap_parent(unode);
            bits_out[pnode-1] = heap_is_left(unode);
            unode             = pnode;
        end
    end

endmodule

// File: rtl/plru_replace_d1.sv
// Per-set tree-PLRU victim selector with invalid-way preference and init sweep.
// Optional PLRU_REPLACE_BYPASS_EN forwards a same-set same-cycle touch into the lookup.
module plru_replace_d1
    import plru_replace_d1_pkg::*;
#(
    parameter int DEPTH      = 256,
    parameter int WAY_NUM    = 4,
    parameter int WAY_WIDTH  = $clog2(WAY_NUM),
    parameter int ADDR_WIDTH = $clog2(DEPTH)
) (
    input  logic            clk,
    input  logic            rst,
    plru_replace_d1_if.slave bus
);

    localparam int NB = plru_bits(WAY_NUM);
    localparam logic [ADDR_WIDTH-1:0] LAST_IDX = ADDR_WIDTH'(DEPTH - 1);

    if (WAY_NUM < 2 || (WAY_NUM & (WAY_NUM - 1)) != 0) begin : g_bad_way_num
        $error("plru_replace_d1: WAY_NUM must be a power of two >= 2");
    end

    logic [NB-1:0] state_mem [DEPTH];

    fsm_state_t            state_reg, state_next;
    logic [ADDR_WIDTH-1:0] sweep_reg, sweep_next;
    logic                  miss_way_valid_reg;
    logic [WAY_WIDTH-1:0]  miss_way_reg;

    logic                  lookup_fire, touch_fire;
    logic [NB-1:0]         lookup_bits_raw, lookup_bits;
    logic [NB-1:0]         touch_bits_raw, touch_bits_new;
    logic [NB-1:0]         lookup_bits_unused;
    logic [WAY_WIDTH-1:0]  touch_victim_unused;
    logic [WAY_WIDTH-1:0]  tree_victim;
    logic [WAY_NUM-1:0]    invalid_mask;
    logic                  any_invalid;
    logic [WAY_WIDTH-1:0]  first_invalid;
    logic [WAY_WIDTH-1:0]  victim_sel;

    assign bus.ready          = (state_reg == RUN);
    assign bus.miss_way_valid = miss_way_valid_reg;
    assign bus.miss_way       = miss_way_reg;

    assign lookup_fire = bus.lookup_en & bus.ready;
    assign touch_fire  = bus.touch_en & bus.ready;

    always_comb begin
        state_next = state_reg;
        sweep_next = sweep_reg;
        case (state_reg)
            INIT: begin
                if (sweep_reg == LAST_IDX) begin
                    state_next = RUN;
                end else begin
                    sweep_next = sweep_reg + 1'b1;
                end
            end
            RUN:     state_next = RUN;
            default: state_next = INIT;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_reg <= INIT;
            sweep_reg <= '0;
        end else begin
            state_reg <= state_next;
            sweep_reg <= sweep_next;
        end
    end

    // Single write port: the sweep owns it during INIT, touches own it afterwards.
    always_ff @(posedge clk) begin
        if (!rst) begin
            if (state_reg == INIT) begin
                state_mem[sweep_reg] <= '0;
            end else if (touch_fire) begin
                state_mem[bus.touch_idx] <= touch_bits_new;
            end
        end
    end

    assign lookup_bits_raw = state_mem[bus.lookup_idx];
    assign touch_bits_raw  = state_mem[bus.touch_idx];

`ifdef PLRU_REPLACE_BYPASS_EN
    assign lookup_bits = (touch_fire && (bus.touch_idx == bus.lookup_idx))
                       ? touch_bits_new : lookup_bits_raw;
`else
    assign lookup_bits = lookup_bits_raw;
`endif

    plru_tree #(.WAY_NUM(WAY_NUM), .WAY_WIDTH(WAY_WIDTH)) u_touch_tree (
        .bits_in    (touch_bits_raw),
        .touch_way  (bus.touch_way),
        .victim_way (touch_victim_unused),
        .bits_out   (touch_bits_new)
    );

    plru_tree #(.WAY_NUM(WAY_NUM), .WAY_WIDTH(WAY_WIDTH)) u_lookup_tree (
        .bits_in    (lookup_bits),
        .touch_way  (bus.touch_way),
        .victim_way (tree_victim),
        .bits_out   (lookup_bits_unused)
    );

    for (genvar gi = 0; gi < WAY_NUM; gi++) begin : g_invalid
        assign invalid_mask[gi] = ~bus.lookup_valid[gi];
    end

    always_comb begin
        any_invalid   = 1'b0;
        first_invalid = '0;
        for (int w = WAY_NUM - 1; w >= 0; w--) begin
            if (invalid_mask[w]) begin
                any_invalid   = 1'b1;
                first_invalid = WAY_WIDTH'(w);
            end
        end
    end

    assign victim_sel = any_invalid ? first_invalid : tree_victim;

    always_ff @(posedge clk) begin
        if (rst) begin
            miss_way_valid_reg <= 1'b0;
            miss_way_reg       <= '0;
        end else begin
            miss_way_valid_reg <= lookup_fire;
            if (lookup_fire) begin
                miss_way_reg <= victim_sel;
            end
        end
    end

endmodule

// File: tb/tb_plru_replace_d1.sv
// Directed bench for plru_replace_d1 (DEPTH=8, WAY_NUM=4); one line per transaction.
module tb_plru_replace_d1;

    localparam int DEPTH   = 8;
    localparam int WAY_NUM = 4;

    logic clk = 1'b0;
    logic rst = 1'b1;
    int   n_checks = 0;
    int   n_errors = 0;

    always #5 clk = ~clk;

    plru_replace_d1_if #(.DEPTH(DEPTH), .WAY_NUM(WAY_NUM)) bus ();

    plru_replace_d1 #(.DEPTH(DEPTH), .WAY_NUM(WAY_NUM)) dut (
        .clk (clk),
        .rst (rst),
        .bus (bus)
    );

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        assert (got === exp) else begin
            n_errors++;
            $error("FAIL %s: observed=%0d expected=%0d", tag, got, exp);
        end
    endtask

    // Lookup at edge T; result and one-cycle pulse checked after T and T+1.
    task automatic do_lookup(input string tag, input int idx, input logic [3:0] valid, input int exp_way);
        bus.lookup_en    = 1'b1;
        bus.lookup_idx   = 3'(idx);
        bus.lookup_valid = valid;
        tick();
        bus.lookup_en = 1'b0;
        $display("lookup %s idx=%0d valid=%b -> way=%0d vld=%0d", tag, idx, valid,
                 bus.miss_way, bus.miss_way_valid);
        check({tag, "_vld"}, 32'(bus.miss_way_valid), 32'd1);
        check({tag, "_way"}, 32'(bus.miss_way), 32'(exp_way));
        tick();
        check({tag, "_pulse"}, 32'(bus.miss_way_valid), 32'd0);
        check({tag, "_hold"}, 32'(bus.miss_way), 32'(exp_way));
    endtask

    task automatic do_touch(input int idx, input int way);
        bus.touch_en  = 1'b1;
        bus.touch_idx = 3'(idx);
        bus.touch_way = 2'(way);
        tick();
        bus.touch_en = 1'b0;
        $display("touch idx=%0d way=%0d", idx, way);
    endtask

    initial begin
        int exp_same;
        bus.lookup_en    = 1'b0;
        bus.lookup_idx   = '0;
        bus.lookup_valid = '1;
        bus.touch_en     = 1'b0;
        bus.touch_idx    = '0;
        bus.touch_way    = '0;

        // 1. reset and init sweep; lookups held high during INIT must be ignored
        rst = 1'b1;
        tick();
        tick();
        check("rst_ready", 32'(bus.ready), 32'd0);
        check("rst_vld", 32'(bus.miss_way_valid), 32'd0);
        check("rst_way", 32'(bus.miss_way), 32'd0);
        rst = 1'b0;
        bus.lookup_en  = 1'b1;
        bus.lookup_idx = 3'd5;
        for (int c = 1; c <= DEPTH; c++) begin
            tick();
            $display("init cycle %0d ready=%0d vld=%0d", c, bus.ready, bus.miss_way_valid);
            check($sformatf("init_ready_%0d", c), 32'(bus.ready), (c == DEPTH) ? 32'd1 : 32'd0);
            check($sformatf("init_vld_%0d", c), 32'(bus.miss_way_valid), 32'd0);
        end
        bus.lookup_en = 1'b0;

        // 2. first lookup on a cleared set
        do_lookup("t2", 5, 4'b1111, 0);

        // 3. touch-the-victim rotation
        do_touch(5, 0);
        do_lookup("t3a", 5, 4'b1111, 2);
        do_touch(5, 2);
        do_lookup("t3b", 5, 4'b1111, 1);
        do_touch(5, 1);
        do_lookup("t3c", 5, 4'b1111, 3);
        do_touch(5, 3);
        do_lookup("t3d", 5, 4'b1111, 0);

        // 4. invalid way preferred, state untouched
        do_lookup("t4_inv", 5, 4'b1011, 2);
        do_lookup("t4_plru", 5, 4'b1111, 0);

        // 5. same-set same-cycle lookup and touch
`ifdef PLRU_REPLACE_BYPASS_EN
        exp_same = 2;
`else
        exp_same = 0;
`endif
        bus.touch_en  = 1'b1;
        bus.touch_idx = 3'd3;
        bus.touch_way = 2'd0;
        do_lookup("t5_same", 3, 4'b1111, exp_same);
        bus.touch_en = 1'b0;
        do_lookup("t5_next", 3, 4'b1111, 2);

        // 6. dirty set 7, then reset, re-reset mid-sweep, and confirm it is cleared
        do_touch(7, 0);
        do_touch(7, 3);
        do_lookup("t6_pre", 7, 4'b1111, 1);
        rst = 1'b1;
        tick();
        rst = 1'b0;
        tick();
        tick();
        tick();
        check("t6_mid_ready", 32'(bus.ready), 32'd0);
        rst = 1'b1;
        tick();
        check("t6_rst_vld", 32'(bus.miss_way_valid), 32'd0);
        rst = 1'b0;
        for (int c = 1; c <= DEPTH; c++) begin
            tick();
            check($sformatf("t6_ready_%0d", c), 32'(bus.ready), (c == DEPTH) ? 32'd1 : 32'd0);
        end
        $display("re-init done ready=%0d", bus.ready);
        do_lookup("t6_post", 7, 4'b1111, 0);

        $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
        $finish;
    end

endmodule
